// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing generator with four selectable test patterns.
// Sync, de, colour and frame_start leave through two register stages behind the x/y counters.
module vga_pattern_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   COLOR_BITS = 4,
  parameter int   FRAME_BITS = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  button,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [31:0]   HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0]   HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0]   VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0]   VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0]   X_ACT    = 32'(H_ACTIVE);
  localparam logic [31:0]   Y_ACT    = 32'(V_ACTIVE);
  localparam logic [31:0]   CX       = 32'(H_ACTIVE / 2);
  localparam logic [31:0]   CY       = 32'(V_ACTIVE / 2);
  localparam logic [31:0]   BAR_W    = 32'((H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1);

  typedef enum logic [1:0] {
    MODE_DIAMOND  = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } patternMode_t;

  logic [XW-1:0] xCount;
  logic [YW-1:0] yCount;
  logic          atWrap;
  logic          btnMeta;
  logic          btnSync;
  logic          btnQ;
  patternMode_t  modeQ;

  assign atWrap = (xCount == X_LAST) && (yCount == Y_LAST);

  // Mode and button are only taken at the frame wrap so a frame is never drawn with two patterns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xCount <= '0;
      yCount <= '0;
      frame  <= '0;
      modeQ  <= MODE_DIAMOND;
      btnQ   <= 1'b0;
    end else begin
      if (xCount == X_LAST) begin
        xCount <= '0;
        yCount <= (yCount == Y_LAST) ? '0 : yCount + 1'b1;
      end else begin
        xCount <= xCount + 1'b1;
      end
      if (atWrap) begin
        frame <= frame + 1'b1;
        modeQ <= patternMode_t'(mode);
        btnQ  <= btnSync;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btnMeta <= 1'b0;
      btnSync <= 1'b0;
    end else begin
      btnMeta <= button;
      btnSync <= btnMeta;
    end
  end

  logic [31:0]           xExt;
  logic [31:0]           yExt;
  logic [31:0]           frameExt;
  logic [31:0]           dx;
  logic [31:0]           dy;
  logic [31:0]           barIdx;
  logic [31:0]           scrollSum;
  logic [11:0]           dm;
  logic [23:0]           dShift;
  logic [23:0]           d;
  logic [2:0]            barK;
  logic                  checkerOn;
  logic                  hsActive;
  logic                  vsActive;
  logic                  deNow;
  logic [COLOR_BITS-1:0] pixR;
  logic [COLOR_BITS-1:0] pixG;
  logic [COLOR_BITS-1:0] pixB;
  logic                  unusedBits;

  // Pixel colour for the current counter position; everything is blanked outside the active area.
  always_comb begin
    xExt      = 32'(xCount);
    yExt      = 32'(yCount);
    frameExt  = 32'(frame);
    dx        = (xExt >= CX) ? (xExt - CX) : (CX - xExt);
    dy        = (yExt >= CY) ? (yExt - CY) : (CY - yExt);
    dm        = 12'(dx + dy);
    dShift    = btnQ ? (24'(dm) << dm[6:5]) : (24'(dm) >> dm[4:3]);
    d         = dShift - frameExt[23:0];
    barIdx    = xExt / BAR_W;
    barK      = (barIdx > 32'd7) ? 3'd0 : 3'(32'd7 - barIdx);
    scrollSum = xExt + frameExt;
    checkerOn = scrollSum[5] ^ yExt[5];
    hsActive  = (xExt >= HS_START) && (xExt < HS_END);
    vsActive  = (yExt >= VS_START) && (yExt < VS_END);
    deNow     = (xExt < X_ACT) && (yExt < Y_ACT);
    pixR      = '0;
    pixG      = '0;
    pixB      = '0;
    if (deNow) begin
      case (modeQ)
        MODE_DIAMOND: begin
          pixR = d[COLOR_BITS+3:4];
          pixG = d[COLOR_BITS+2:3];
          pixB = d[COLOR_BITS+1:2];
        end
        MODE_BARS: begin
          pixR = {COLOR_BITS{barK[2]}};
          pixG = {COLOR_BITS{barK[1]}};
          pixB = {COLOR_BITS{barK[0]}};
        end
        MODE_CHECKER: begin
          pixR = {COLOR_BITS{checkerOn}};
          pixG = {COLOR_BITS{checkerOn}};
          pixB = {COLOR_BITS{checkerOn}};
        end
        MODE_GRADIENT: begin
          pixR = xExt[COLOR_BITS+3:4];
          pixG = yExt[COLOR_BITS+3:4];
          pixB = frameExt[COLOR_BITS-1:0];
        end
      endcase
    end
  end

  assign unusedBits = ^{scrollSum, d, frameExt, yExt};

  logic                  s1Hsync;
  logic                  s1Vsync;
  logic                  s1De;
  logic                  s1Fs;
  logic [COLOR_BITS-1:0] s1R;
  logic [COLOR_BITS-1:0] s1G;
  logic [COLOR_BITS-1:0] s1B;

  // Two aligned stages; reset flushes both so nothing stale escapes after release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Hsync     <= ~HSYNC_POL;
      s1Vsync     <= ~VSYNC_POL;
      s1De        <= 1'b0;
      s1Fs        <= 1'b0;
      s1R         <= '0;
      s1G         <= '0;
      s1B         <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      s1Hsync     <= hsActive ? HSYNC_POL : ~HSYNC_POL;
      s1Vsync     <= vsActive ? VSYNC_POL : ~VSYNC_POL;
      s1De        <= deNow;
      s1Fs        <= (xCount == '0) && (yCount == '0);
      s1R         <= pixR;
      s1G         <= pixG;
      s1B         <= pixB;
      hsync       <= s1Hsync;
      vsync       <= s1Vsync;
      de          <= s1De;
      frame_start <= s1Fs;
      r           <= s1R;
      g           <= s1G;
      b           <= s1B;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: three instances (mid-size, default, tiny with inverted polarity) checked
// cycle by cycle against an arithmetic model of the timing and pattern rules.
module tb_vga_pattern_gen;

  localparam int A_HA = 64, A_HFP = 4, A_HS = 8, A_HBP = 4;
  localparam int A_VA = 40, A_VFP = 2, A_VS = 3, A_VBP = 5;
  localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
  localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;
  localparam int A_L  = A_HT * A_VT;
  localparam int A_FB = 12;

  localparam int C_HA = 8, C_HFP = 2, C_HS = 2, C_HBP = 2;
  localparam int C_VA = 4, C_VFP = 1, C_VS = 1, C_VBP = 1;
  localparam int C_HT = C_HA + C_HFP + C_HS + C_HBP;
  localparam int C_VT = C_VA + C_VFP + C_VS + C_VBP;
  localparam int C_L  = C_HT * C_VT;
  localparam int C_FB = 3;

  localparam int RUN_CYCLES = 9 * A_L;

  logic clock;
  logic resetA;
  logic resetB;
  logic [1:0] modeA, modeC;
  logic btnA, btnC;

  logic hsyncA, vsyncA, deA, fsA;
  logic [3:0] rA, gA, bA;
  logic [A_FB-1:0] frameA;
  logic hsyncB, vsyncB, deB, fsB;
  logic [3:0] rB, gB, bB;
  logic [11:0] frameB;
  logic hsyncC, vsyncC, deC, fsC;
  logic [3:0] rC, gC, bC;
  logic [C_FB-1:0] frameC;

  int total = 0;
  int bad = 0;
  int edgeCount = 0;
  bit checkOn = 0;
  int modeLogA[int];
  int btnLogA[int];
  int modeLogC[int];
  int btnLogC[int];

  vga_pattern_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_BITS(4), .FRAME_BITS(A_FB)
  ) dutA (
    .clock(clock), .reset(resetA), .mode(modeA), .button(btnA),
    .hsync(hsyncA), .vsync(vsyncA), .de(deA), .r(rA), .g(gA), .b(bA),
    .frame(frameA), .frame_start(fsA)
  );

  vga_pattern_gen dutB (
    .clock(clock), .reset(resetB), .mode(2'd0), .button(1'b0),
    .hsync(hsyncB), .vsync(vsyncB), .de(deB), .r(rB), .g(gB), .b(bB),
    .frame(frameB), .frame_start(fsB)
  );

  vga_pattern_gen #(
    .H_ACTIVE(C_HA), .H_FP(C_HFP), .H_SYNC(C_HS), .H_BP(C_HBP),
    .V_ACTIVE(C_VA), .V_FP(C_VFP), .V_SYNC(C_VS), .V_BP(C_VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_BITS(4), .FRAME_BITS(C_FB)
  ) dutC (
    .clock(clock), .reset(resetA), .mode(modeC), .button(btnC),
    .hsync(hsyncC), .vsync(vsyncC), .de(deC), .r(rC), .g(gC), .b(bC),
    .frame(frameC), .frame_start(fsC)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge numbering since release, plus what mode/button each edge saw.
  always @(posedge clock) begin
    if (resetA) begin
      edgeCount = 0;
    end else begin
      edgeCount = edgeCount + 1;
      modeLogA[edgeCount] = modeA;
      btnLogA[edgeCount]  = btnA;
      modeLogC[edgeCount] = modeC;
      btnLogC[edgeCount]  = btnC;
    end
  end

  // Pixel rules written as plain arithmetic on the pixel position and frame number.
  function automatic void pixelModel(input int ha, hfp, hs, va, vfp, vs, input bit hpol, vpol,
                                     input int cb, x, y, fr, md, bt,
                                     output bit eh, ev, ede, output int er, eg, eb);
    int mask, cx, cy, dm, v, d, k, c;
    mask = (1 << cb) - 1;
    eh   = (x >= ha + hfp && x < ha + hfp + hs) ? hpol : !hpol;
    ev   = (y >= va + vfp && y < va + vfp + vs) ? vpol : !vpol;
    ede  = (x < ha) && (y < va);
    er = 0; eg = 0; eb = 0;
    if (ede) begin
      case (md)
        0: begin
          cx = ha / 2;
          cy = va / 2;
          dm = ((x > cx) ? x - cx : cx - x) + ((y > cy) ? y - cy : cy - y);
          dm = dm % 4096;
          if (bt != 0) v = dm * (1 << ((dm / 32) % 4));
          else         v = dm / (1 << ((dm / 8) % 4));
          d  = (v - fr) & 'hFFFFFF;
          er = (d / 16) & mask;
          eg = (d / 8) & mask;
          eb = (d / 4) & mask;
        end
        1: begin
          k  = 7 - x / (ha / 8);
          er = ((k & 4) != 0) ? mask : 0;
          eg = ((k & 2) != 0) ? mask : 0;
          eb = ((k & 1) != 0) ? mask : 0;
        end
        2: begin
          c  = ((x + fr) / 32 + y / 32) % 2;
          er = (c != 0) ? mask : 0;
          eg = er;
          eb = er;
        end
        default: begin
          er = (x / 16) & mask;
          eg = (y / 16) & mask;
          eb = fr & mask;
        end
      endcase
    end
  endfunction

  task automatic checkValue(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input string name, input int k,
                             input int ha, hfp, hs, va, vfp, vs, input bit hpol, vpol,
                             input int ht, vt, fb, md, bt, input logic [43:0] act);
    int idx, x, y, fr, er, eg, eb, eframe;
    bit eh, ev, ede, efs;
    logic [43:0] req;
    eframe = (k / (ht * vt)) % (1 << fb);
    if (k < 2) begin
      eh = !hpol; ev = !vpol; ede = 0; er = 0; eg = 0; eb = 0; efs = 0;
    end else begin
      idx = k - 2;
      x   = idx % ht;
      y   = (idx / ht) % vt;
      fr  = (idx / (ht * vt)) % (1 << fb);
      efs = (idx % (ht * vt)) == 0;
      pixelModel(ha, hfp, hs, va, vfp, vs, hpol, vpol, 4, x, y, fr, md, bt, eh, ev, ede, er, eg, eb);
    end
    req = {eh, ev, ede, 8'(er), 8'(eg), 8'(eb), efs, 16'(eframe)};
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s edge=%0d actual=%h required=%h", name, k, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (checkOn && !resetA && edgeCount >= 1) begin
      int f, md, bt;
      f  = (edgeCount >= 2) ? (edgeCount - 2) / A_L : 0;
      md = (f == 0) ? 0 : modeLogA[f * A_L];
      bt = (f == 0) ? 0 : btnLogA[f * A_L - 2];
      checkOutput("dutA", edgeCount, A_HA, A_HFP, A_HS, A_VA, A_VFP, A_VS, 1'b0, 1'b0,
                  A_HT, A_VT, A_FB, md, bt,
                  {hsyncA, vsyncA, deA, 8'(rA), 8'(gA), 8'(bA), fsA, 16'(frameA)});
    end
  end

  always @(negedge clock) begin
    if (checkOn && !resetA && edgeCount >= 1) begin
      int f, md, bt;
      f  = (edgeCount >= 2) ? (edgeCount - 2) / C_L : 0;
      md = (f == 0) ? 0 : modeLogC[f * C_L];
      bt = (f == 0) ? 0 : btnLogC[f * C_L - 2];
      checkOutput("dutC", edgeCount, C_HA, C_HFP, C_HS, C_VA, C_VFP, C_VS, 1'b1, 1'b1,
                  C_HT, C_VT, C_FB, md, bt,
                  {hsyncC, vsyncC, deC, 8'(rC), 8'(gC), 8'(bC), fsC, 16'(frameC)});
    end
  end

  task automatic pinPixel(input string name, input int x, y, fr, md, bt, input int reqRgb);
    bit eh, ev, ede;
    int er, eg, eb;
    pixelModel(640, 16, 96, 480, 10, 2, 1'b0, 1'b0, 4, x, y, fr, md, bt, eh, ev, ede, er, eg, eb);
    checkValue(name, er * 256 + eg * 16 + eb, reqRgb);
  endtask

  // Hand-derived values at the default 640x480 timing keep the model honest.
  task automatic pinModel;
    bit eh, ev, ede;
    int er, eg, eb;
    pinPixel("pinDiamondCenter", 320, 240, 0, 0, 0, 'h000);
    pinPixel("pinDiamond330",    330, 240, 0, 0, 0, 'h001);
    pinPixel("pinDiamondBtn",    330, 240, 0, 0, 1, 'h012);
    pinPixel("pinDiamondWrap",   330, 240, 6, 0, 0, 'hFFF);
    pinPixel("pinBars0",         0,   10,  0, 1, 0, 'hFFF);
    pinPixel("pinBars560",       560, 10,  0, 1, 0, 'h000);
    pinPixel("pinBars80",        80,  10,  0, 1, 0, 'hFF0);
    pinPixel("pinChecker32",     32,  0,   0, 2, 0, 'hFFF);
    pinPixel("pinCheckerScroll", 31,  0,   1, 2, 0, 'hFFF);
    pinPixel("pinCheckerBoth",   32,  32,  0, 2, 0, 'h000);
    pinPixel("pinGradient",      80,  48,  26, 3, 0, 'h53A);
    pinPixel("pinBlank",         640, 0,   0, 1, 0, 'h000);
    pixelModel(640, 16, 96, 480, 10, 2, 1'b0, 1'b0, 4, 655, 0, 0, 0, 0, eh, ev, ede, er, eg, eb);
    checkValue("pinHsyncBefore", int'(eh), 1);
    pixelModel(640, 16, 96, 480, 10, 2, 1'b0, 1'b0, 4, 656, 0, 0, 0, 0, eh, ev, ede, er, eg, eb);
    checkValue("pinHsyncStart", int'(eh), 0);
    pixelModel(640, 16, 96, 480, 10, 2, 1'b0, 1'b0, 4, 752, 490, 0, 0, 0, eh, ev, ede, er, eg, eb);
    checkValue("pinHsyncEnd", int'(eh), 1);
    checkValue("pinVsyncStart", int'(ev), 0);
  endtask

  // Random mode/button activity, plus deliberate changes right at the capture boundaries.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if ((edgeCount + 1) % A_L == 0) modeA = 2'((modeA + 1) % 4);
      else if ($urandom_range(0, 799) == 0) modeA = 2'($urandom_range(0, 3));
      if ((edgeCount + 3) % (2 * A_L) == 0 || (edgeCount + 2) % (2 * A_L) == A_L) btnA = ~btnA;
      else if ($urandom_range(0, 1499) == 0) btnA = ~btnA;
      if ($urandom_range(0, 39) == 0) modeC = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) btnC = ~btnC;
    end
  endtask

  task automatic testFramePeriod;
    int lastEdge = 0;
    int waited;
    for (int n = 0; n < 30; n++) begin
      waited = 0;
      do begin
        @(negedge clock);
        waited++;
      end while (!fsC && waited < 200);
      if (!fsC) begin
        total++;
        bad++;
        $display("[TB] FAIL frameStartTimeout actual=none required=pulse");
        break;
      end
      checkValue("smallFrameAtPulse", int'(frameC), n % 8);
      if (n == 0) checkValue("smallFirstPulseEdge", edgeCount, 2);
      else        checkValue("smallFramePeriod", edgeCount - lastEdge, 98);
      lastEdge = edgeCount;
    end
  endtask

  task automatic testDefault;
    int hl, dl, vl;
    repeat (300) @(negedge clock);
    resetB = 1'b1;
    #1;
    checkValue("resetImmediate", int'({hsyncB, vsyncB, deB, rB, gB, bB, fsB, frameB}), 'hC000000);
    repeat (5) begin
      @(negedge clock);
      checkValue("resetHeld", int'({hsyncB, vsyncB, deB, rB, gB, bB, fsB, frameB}), 'hC000000);
    end
    resetB = 1'b0;
    @(negedge clock);
    checkValue("fsEdge1", int'(fsB), 0);
    @(negedge clock);
    checkValue("fsEdge2", int'(fsB), 1);
    checkValue("pixel00De", int'(deB), 1);
    checkValue("pixel00Rgb", int'({rB, gB, bB}), 'h813);
    @(negedge clock);
    checkValue("fsEdge3", int'(fsB), 0);
    for (int line = 0; line < 10; line++) begin
      hl = 0; dl = 0; vl = 0;
      repeat (800) begin
        @(negedge clock);
        if (!hsyncB) hl++;
        if (deB) dl++;
        if (!vsyncB) vl++;
      end
      checkValue("hsyncLowPerLine", hl, 96);
      checkValue("deHighPerLine", dl, 640);
      checkValue("vsyncIdle", vl, 0);
    end
  endtask

  initial begin
    resetA = 1'b0;
    resetB = 1'b0;
    modeA = 2'd0; modeC = 2'd0;
    btnA = 1'b0;  btnC = 1'b0;
    #2;
    resetA = 1'b1;
    resetB = 1'b1;
    repeat (3) @(negedge clock);
    pinModel();
    resetA = 1'b0;
    resetB = 1'b0;
    checkOn = 1'b1;
    fork
      applyStimulus(RUN_CYCLES);
      testFramePeriod();
      testDefault();
    join
    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator, replacing the fixed 640x480 diamond generator. Produces hsync/vsync/de and COLOR_BITS-per-channel RGB from a single pixel clock. Porch, sync and polarity values are parameters. Supports four pattern modes selected at frame boundaries, plus a synchronous frame counter with a frame-start strobe for downstream logic.

Parameters:
H_ACTIVE 640 visible pixels per line
H_FP 16 / H_SYNC 96 / H_BP 48 horizontal front porch / sync / back porch, in clocks
V_ACTIVE 480 visible lines
V_FP 10 / V_SYNC 2 / V_BP 33 vertical front porch / sync / back porch, in lines
HSYNC_POL 0 / VSYNC_POL 0 active sync level (0 = active-low)
COLOR_BITS 4 bits per channel, 1..8
FRAME_BITS 12 frame counter width

Ports:
clock in 1 pixel clock
reset in 1 asynchronous, active-high
mode in 2 pattern select (0 diamond, 1 bars, 2 checker, 3 gradient)
button in 1 asynchronous input; selects diamond shift variant
hsync out 1 horizontal sync
vsync out 1 vertical sync
de out 1 active-video flag
r, g, b out COLOR_BITS each colour channels
frame out FRAME_BITS current frame number
frame_start out 1 one-clock pulse aligned with output pixel (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP, V_TOTAL likewise. Counters x and y are clog2-sized.
- x counts 0..H_TOTAL-1 and wraps to 0. y increments only on x wrap and wraps 0 after V_TOTAL-1.
- Sync is active when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (same form for y). Pin level = active ? *_POL : ~*_POL.
- de = (x < H_ACTIVE) && (y < V_ACTIVE). r/g/b are forced to 0 whenever de = 0.
- Latency: hsync, vsync, de, r/g/b and frame_start for counter state (x,y) all appear registered exactly 2 clocks later, mutually aligned.
- frame increments on the clock where (x,y) wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0), modulo 2^FRAME_BITS. It is clock-domain logic only; no derived clocks.
- button passes through a 2-flop synchroniser. The synchronised button and mode are captured into mode_q/btn_q only at that same wrap edge. A mid-frame change never tears.
- Mode 0 (diamond): cx = H_ACTIVE/2, cy = V_ACTIVE/2, dm = |x-cx| + |y-cy| (12 bit).
  - d = btn_q ? (dm << dm[6:5]) - frame : (dm >> dm[4:3]) - frame, as 24-bit two's-complement wrap.
  - r = d[COLOR_BITS+3:4], g = d[COLOR_BITS+2:3], b = d[COLOR_BITS+1:2].
- Mode 1 (bars): 8 bars, each H_ACTIVE/8 wide. k = 7 - bar_index. r = all k[2], g = all k[1], b = all k[0]. Bar 0 is white, bar 7 is black.
- Mode 2 (checker): c = (x + frame)[5] ^ y[5]. All channels are all-ones if c, else 0. The pattern scrolls 1 px/frame.
- Mode 3 (gradient): r = x[COLOR_BITS+3:4], g = y[COLOR_BITS+3:4], b = frame[COLOR_BITS-1:0].
- Reset, asserted at any time, takes effect immediately:
  - x = y = 0, frame = 0, mode_q = 0, btn_q = 0, synchroniser cleared.
  - Pipeline flushed; de = 0, rgb = 0, frame_start = 0, syncs at inactive level.
- After reset release, counter (0,0) is present on the first edge. frame_start pulses on the 2nd edge after release. The first frame uses frame = 0.
- Simultaneous mode change and wrap edge: the new value is captured and applies to the frame starting at (0,0).

Test Plan:
- Reset held 5 clocks mid-line at default params -> hsync = vsync = 1, de = 0, rgb = 0, frame = 0. frame_start pulses 2 clocks after release.
- Free-run default params -> hsync low exactly 96 clocks in every 800-clock period. vsync low 1600 clocks per 420000. de high 640 clocks/line for 480 lines.
- Small params (H 8/2/2/2, V 4/1/1/1, FRAME_BITS 3) -> frame steps 0..7 then 0. frame_start period is 14*7 = 98 clocks.
- Mode 0, button = 0, frame 0, default params -> pixel (320,240) rgb = 0,0,0. Pixel (330,240) (dm = 10, d = 5) rgb = 0,0,1.
- Mode switched 0 -> 1 mid-frame -> current frame stays diamond. Next frame: x = 0 is rgb F,F,F; x = 560 is 0,0,0; x = 80 is F,F,0.
- Run with HSYNC_POL = 1, VSYNC_POL = 1 -> sync pulses are high with identical timing; de and rgb are unchanged.
